// File: rtl/ahb_lite_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ahb_lite_master : valid/ready command stream to pipelined AHB-Lite master
//                   with wait-state, two-cycle ERROR and address replay.
// Optional feature macro: WAIT_TIMEOUT_EN (sticky wait-state timeout flag)
// Revision: 1.0
// ---------------------------------------------------------------------------
module ahb_lite_master #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  input  logic                  HRESP,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  timeout_flag
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    ERR2   = 2'd1,
    REPLAY = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  a_valid_q, a_valid_d;
  logic [ADDR_WIDTH-1:0] a_addr_q, a_addr_d;
  logic                  a_write_q, a_write_d;
  logic [DATA_WIDTH-1:0] a_wdata_q, a_wdata_d;
  logic                  d_valid_q, d_valid_d;
  logic                  d_write_q, d_write_d;
  logic [DATA_WIDTH-1:0] d_wdata_q, d_wdata_d;
  logic                  r_valid_q, r_valid_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic                  r_write_q, r_write_d;
  logic [DATA_WIDTH-1:0] r_wdata_q, r_wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_error_q, rsp_error_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  assign cmd_ready = HREADY && (state_q == RUN) && !r_valid_q;

  assign HADDR     = a_addr_q;
  assign HTRANS    = {a_valid_q, 1'b0};
  assign HWRITE    = a_write_q;
  assign HWDATA    = d_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;
  assign rsp_rdata = rsp_rdata_q;

  always_comb begin
    state_d     = state_q;
    a_valid_d   = a_valid_q;
    a_addr_d    = a_addr_q;
    a_write_d   = a_write_q;
    a_wdata_d   = a_wdata_q;
    d_valid_d   = d_valid_q;
    d_write_d   = d_write_q;
    d_wdata_d   = d_wdata_q;
    r_valid_d   = r_valid_q;
    r_addr_d    = r_addr_q;
    r_write_d   = r_write_q;
    r_wdata_d   = r_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = rsp_error_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      RUN: begin
        if (HREADY) begin
          if (d_valid_q) begin
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b0;
            if (!d_write_q) rsp_rdata_d = HRDATA;
          end
          d_valid_d = a_valid_q;
          d_write_d = a_write_q;
          d_wdata_d = a_wdata_q;
          if (cmd_valid && cmd_ready) begin
            a_valid_d = 1'b1;
            a_addr_d  = cmd_addr;
            a_write_d = cmd_write;
            a_wdata_d = cmd_wdata;
          end else begin
            a_valid_d = 1'b0;
          end
        end else if (HRESP && d_valid_q) begin
          // First ERROR cycle: park the pending address phase for replay and cancel it on the bus
          if (a_valid_q) begin
            r_valid_d = 1'b1;
            r_addr_d  = a_addr_q;
            r_write_d = a_write_q;
            r_wdata_d = a_wdata_q;
          end
          a_valid_d = 1'b0;
          state_d   = ERR2;
        end
      end
      ERR2: begin
        if (HREADY) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          d_valid_d   = 1'b0;
          state_d     = r_valid_q ? REPLAY : RUN;
        end
      end
      REPLAY: begin
        a_valid_d = 1'b1;
        a_addr_d  = r_addr_q;
        a_write_d = r_write_q;
        a_wdata_d = r_wdata_q;
        r_valid_d = 1'b0;
        state_d   = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= RUN;
      a_valid_q   <= 1'b0;
      a_addr_q    <= '0;
      a_write_q   <= 1'b0;
      a_wdata_q   <= '0;
      d_valid_q   <= 1'b0;
      d_write_q   <= 1'b0;
      d_wdata_q   <= '0;
      r_valid_q   <= 1'b0;
      r_addr_q    <= '0;
      r_write_q   <= 1'b0;
      r_wdata_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      a_valid_q   <= a_valid_d;
      a_addr_q    <= a_addr_d;
      a_write_q   <= a_write_d;
      a_wdata_q   <= a_wdata_d;
      d_valid_q   <= d_valid_d;
      d_write_q   <= d_write_d;
      d_wdata_q   <= d_wdata_d;
      r_valid_q   <= r_valid_d;
      r_addr_q    <= r_addr_d;
      r_write_q   <= r_write_d;
      r_wdata_q   <= r_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef WAIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_flag_q, timeout_flag_d;

  // Counter saturates at TIMEOUT; the flag only reports, the transfer keeps waiting
  always_comb begin
    wait_cnt_d     = wait_cnt_q;
    timeout_flag_d = timeout_flag_q;
    if (HREADY) begin
      wait_cnt_d = '0;
    end else if (d_valid_q && (wait_cnt_q != CNT_W'(TIMEOUT))) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
    if (wait_cnt_d == CNT_W'(TIMEOUT)) timeout_flag_d = 1'b1;
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      wait_cnt_q     <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      wait_cnt_q     <= wait_cnt_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

  assign timeout_flag = timeout_flag_q;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
  assign timeout_flag   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_master.sv
`default_nettype none
// tb_ahb_lite_master : randomized checks of ahb_lite_master against an in-order
// response model, with the bench acting as an AHB-Lite memory slave.
module tb_ahb_lite_master;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam logic [AW-1:0] RO_END = 10'h008;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [DW-1:0] HWDATA;
  logic          HREADY = 1'b1;
  logic          HRESP = 1'b0;
  logic [DW-1:0] HRDATA = '0;
  logic          timeout_flag;

  ahb_lite_master dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
    .timeout_flag(timeout_flag)
  );

  always #5 HCLK = ~HCLK;

  int passed = 0;
  int total  = 0;

  typedef struct packed {logic err; logic rd; logic [DW-1:0] data;} exp_t;
  typedef struct packed {logic err; logic [DW-1:0] data;} obs_t;
  typedef struct packed {logic [AW-1:0] addr; logic wr; logic [31:0] cyc;} aph_t;

  exp_t          exp_q[$];
  obs_t          obs_q[$];
  aph_t          aph_q[$];
  logic [DW-1:0] wlog_q[$];
  logic [DW-1:0] refmem [0:(1<<AW)-1];
  logic [DW-1:0] smem   [0:(1<<AW)-1];
  logic [DW-1:0] model_last = '0;

  // Slave configuration and state
  int            stall_fixed = 0;
  bit            stall_rand  = 1'b0;
  bit            s_dp_valid  = 1'b0;
  logic [AW-1:0] s_dp_addr   = '0;
  bit            s_dp_write  = 1'b0;
  bit            s_dp_err    = 1'b0;
  int            s_err_cyc   = 0;
  int            s_wait      = 0;
  logic [31:0]   cyc_cnt     = '0;
  logic          p_rstn, p_ready, p_write;
  logic [1:0]    p_trans;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;

  always begin
    @(posedge HCLK);
    p_rstn = HRESETn; p_ready = HREADY; p_trans = HTRANS;
    p_addr = HADDR; p_write = HWRITE; p_wdata = HWDATA;
    cyc_cnt = cyc_cnt + 1;
    #1;
    if (!p_rstn) begin
      s_dp_valid = 1'b0;
    end else if (p_ready) begin
      if (s_dp_valid && s_dp_write && !s_dp_err) begin
        smem[s_dp_addr] = p_wdata;
        wlog_q.push_back(p_wdata);
      end
      s_dp_valid = (p_trans == 2'b10);
      if (s_dp_valid) begin
        s_dp_addr  = p_addr;
        s_dp_write = p_write;
        s_dp_err   = p_write && (p_addr < RO_END);
        s_err_cyc  = s_dp_err ? 1 : 0;
        s_wait     = s_dp_err ? 0 : (stall_rand ? int'($urandom_range(0, 2)) : stall_fixed);
        aph_q.push_back('{p_addr, p_write, cyc_cnt});
      end
    end else begin
      if (s_err_cyc == 1) s_err_cyc = 2;
      else if (s_wait > 0) s_wait = s_wait - 1;
    end
    HRDATA = $urandom;
    if (!s_dp_valid)         begin HREADY = 1'b1; HRESP = 1'b0; end
    else if (s_err_cyc == 1) begin HREADY = 1'b0; HRESP = 1'b1; end
    else if (s_err_cyc == 2) begin HREADY = 1'b1; HRESP = 1'b1; end
    else if (s_wait > 0)     begin HREADY = 1'b0; HRESP = 1'b0; end
    else begin
      HREADY = 1'b1; HRESP = 1'b0;
      if (!s_dp_write) HRDATA = smem[s_dp_addr];
    end
  end

  // Bus observer
  int            hold_viol = 0, ready_viol = 0, stall_cyc = 0, err2_cyc = 0, err2_busy = 0;
  logic          m_rstn = 1'b0, m_ready = 1'b1, m_resp = 1'b0, m_write = 1'b0;
  logic [1:0]    m_trans = '0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;

  always @(negedge HCLK) begin
    if (rsp_valid) obs_q.push_back('{rsp_error, rsp_rdata});
    if (!HREADY && cmd_ready) ready_viol++;
    if (HRESETn && !HREADY) stall_cyc++;
    if (HREADY && HRESP) begin
      err2_cyc++;
      if (HTRANS != 2'b00) err2_busy++;
    end
    if (HRESETn && m_rstn && !m_ready) begin
      if (HWDATA != m_wdata) hold_viol++;
      if (!m_resp && (HADDR != m_addr || HTRANS != m_trans || HWRITE != m_write)) hold_viol++;
    end
    m_rstn = HRESETn; m_ready = HREADY; m_resp = HRESP;
    m_addr = HADDR; m_trans = HTRANS; m_write = HWRITE; m_wdata = HWDATA;
  end

  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    bit acc = 1'b0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    while (!acc && n < 500) begin
      @(posedge HCLK);
      acc = cmd_ready;
      n++;
      #1;
    end
    if (!acc) begin
      total++;
      $display("FAIL cmd_accept addr=%0h: not accepted within %0d cycles", a, n);
    end else if (wr) begin
      if (a < RO_END) exp_q.push_back('{1'b1, 1'b0, '0});
      else begin
        refmem[a] = d;
        exp_q.push_back('{1'b0, 1'b0, '0});
      end
    end else begin
      exp_q.push_back('{1'b0, 1'b1, refmem[a]});
    end
  endtask

  task automatic drain();
    int n = 0;
    cmd_valid = 1'b0;
    while (obs_q.size() < exp_q.size() && n < 2000) begin
      @(posedge HCLK); #1; n++;
    end
    repeat (4) @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    total++; if (HTRANS !== 2'b00) $display("FAIL rst_htrans got %0h want 0", HTRANS); else passed++;
    total++; if (HADDR !== '0) $display("FAIL rst_haddr got %0h want 0", HADDR); else passed++;
    total++; if (HWRITE !== 1'b0) $display("FAIL rst_hwrite got %0b want 0", HWRITE); else passed++;
    total++; if (HWDATA !== '0) $display("FAIL rst_hwdata got %0h want 0", HWDATA); else passed++;
    total++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got %0b want 0", rsp_valid); else passed++;
    total++; if (rsp_rdata !== '0) $display("FAIL rst_rsp_rdata got %0h want 0", rsp_rdata); else passed++;
    total++; if (rsp_error !== 1'b0) $display("FAIL rst_rsp_error got %0b want 0", rsp_error); else passed++;
    total++; if (timeout_flag !== 1'b0) $display("FAIL rst_timeout got %0b want 0", timeout_flag); else passed++;
    HRESETn = 1'b1;
    model_last = '0;
    @(posedge HCLK); #1;
  endtask

  task automatic test_write_read();
    int ab = aph_q.size(), wb = wlog_q.size(), ob = obs_q.size();
    stall_fixed = 0;
    send_cmd(1'b1, 10'h010, 32'h0000_00AA);
    send_cmd(1'b0, 10'h010, '0);
    drain();
    total++;
    if (aph_q.size() - ab != 2) $display("FAIL wr_rd_aphase_count got %0d want 2", aph_q.size() - ab);
    else begin
      passed++;
      total++;
      if (aph_q[ab+1].cyc - aph_q[ab].cyc != 1 || aph_q[ab].addr != 10'h010 || aph_q[ab+1].addr != 10'h010)
        $display("FAIL wr_rd_consecutive got cyc %0d/%0d want consecutive at 0x010", aph_q[ab].cyc, aph_q[ab+1].cyc);
      else passed++;
    end
    total++;
    if (wlog_q.size() <= wb || wlog_q[wb] !== 32'h0000_00AA) $display("FAIL wr_rd_hwdata got entries=%0d want 0xAA", wlog_q.size() - wb);
    else passed++;
    total++; if (obs_q.size() != exp_q.size()) $display("FAIL wr_rd_rsp_count got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = ob; i < exp_q.size() && i < obs_q.size(); i++) begin
      if (exp_q[i].rd) model_last = exp_q[i].data;
      total++;
      if (obs_q[i] !== {exp_q[i].err, model_last}) $display("FAIL wr_rd_rsp[%0d] got err=%0b data=%0h want err=%0b data=%0h", i, obs_q[i].err, obs_q[i].data, exp_q[i].err, model_last);
      else passed++;
    end
  endtask

  task automatic test_wait_states();
    int sb = stall_cyc, rb = ready_viol, hb = hold_viol, ob = obs_q.size();
    stall_fixed = 3;
    send_cmd(1'b0, 10'h020, '0);
    send_cmd(1'b0, 10'h024, '0);
    send_cmd(1'b0, 10'h028, '0);
    drain();
    stall_fixed = 0;
    total++; if (stall_cyc - sb != 9) $display("FAIL wait_stall_cycles got %0d want 9", stall_cyc - sb); else passed++;
    total++; if (ready_viol != rb) $display("FAIL wait_ready_low got %0d want 0", ready_viol - rb); else passed++;
    total++; if (hold_viol != hb) $display("FAIL wait_addr_hold got %0d want 0", hold_viol - hb); else passed++;
    total++; if (obs_q.size() != exp_q.size()) $display("FAIL wait_rsp_count got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = ob; i < exp_q.size() && i < obs_q.size(); i++) begin
      if (exp_q[i].rd) model_last = exp_q[i].data;
      total++;
      if (obs_q[i] !== {exp_q[i].err, model_last}) $display("FAIL wait_rsp[%0d] got err=%0b data=%0h want err=%0b data=%0h", i, obs_q[i].err, obs_q[i].data, exp_q[i].err, model_last);
      else passed++;
    end
  endtask

  task automatic test_error_replay();
    int ab = aph_q.size(), eb = err2_cyc, bb = err2_busy, ob = obs_q.size();
    stall_fixed = 0;
    send_cmd(1'b1, 10'h002, $urandom);
    send_cmd(1'b0, 10'h030, '0);
    drain();
    total++; if (err2_cyc - eb != 1) $display("FAIL err_second_cycles got %0d want 1", err2_cyc - eb); else passed++;
    total++; if (err2_busy != bb) $display("FAIL err_htrans_idle got %0d nonidle want 0", err2_busy - bb); else passed++;
    total++;
    if (aph_q.size() - ab != 2 || aph_q[ab].addr != 10'h002 || aph_q[ab+1].addr != 10'h030 || aph_q[ab+1].wr)
      $display("FAIL err_replay_aphase got count=%0d want 2 (0x002 W, 0x030 R)", aph_q.size() - ab);
    else passed++;
    total++; if (obs_q.size() != exp_q.size()) $display("FAIL err_rsp_count got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = ob; i < exp_q.size() && i < obs_q.size(); i++) begin
      if (exp_q[i].rd) model_last = exp_q[i].data;
      total++;
      if (obs_q[i] !== {exp_q[i].err, model_last}) $display("FAIL err_rsp[%0d] got err=%0b data=%0h want err=%0b data=%0h", i, obs_q[i].err, obs_q[i].data, exp_q[i].err, model_last);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int ab = aph_q.size(), hb = hold_viol, wb, ob = obs_q.size();
    logic [DW-1:0] wd [8];
    stall_fixed = 0;
    for (int i = 0; i < 4; i++) send_cmd(1'b0, AW'(10'h040 + i), '0);
    drain();
    for (int i = 1; i < 4; i++) begin
      total++;
      if (aph_q.size() < ab + 4 || aph_q[ab+i].cyc - aph_q[ab+i-1].cyc != 1)
        $display("FAIL b2b_rate[%0d] got aphases=%0d want one per cycle", i, aph_q.size() - ab);
      else passed++;
    end
    wb = wlog_q.size();
    stall_rand = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wd[i] = $urandom;
      send_cmd(1'b1, AW'(10'h040 + i), wd[i]);
    end
    drain();
    stall_rand = 1'b0;
    total++; if (hold_viol != hb) $display("FAIL b2b_hwdata_hold got %0d want 0", hold_viol - hb); else passed++;
    total++;
    if (wlog_q.size() - wb != 8) $display("FAIL b2b_write_count got %0d want 8", wlog_q.size() - wb);
    else begin
      passed++;
      for (int i = 0; i < 8; i++) begin
        total++;
        if (wlog_q[wb+i] !== wd[i]) $display("FAIL b2b_hwdata[%0d] got %0h want %0h", i, wlog_q[wb+i], wd[i]); else passed++;
      end
    end
    total++; if (obs_q.size() != exp_q.size()) $display("FAIL b2b_rsp_count got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = ob; i < exp_q.size() && i < obs_q.size(); i++) begin
      if (exp_q[i].rd) model_last = exp_q[i].data;
      total++;
      if (obs_q[i] !== {exp_q[i].err, model_last}) $display("FAIL b2b_rsp[%0d] got err=%0b data=%0h want err=%0b data=%0h", i, obs_q[i].err, obs_q[i].data, exp_q[i].err, model_last);
      else passed++;
    end
  endtask

  task automatic test_random_mix();
    int hb = hold_viol, rb = ready_viol, ob = obs_q.size();
    stall_rand = 1'b1;
    for (int i = 0; i < 24; i++) begin
      send_cmd(1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), $urandom);
      if ($urandom_range(0, 2) == 0) begin
        cmd_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge HCLK);
        #1;
      end
    end
    drain();
    stall_rand = 1'b0;
    total++; if (hold_viol != hb) $display("FAIL mix_hold got %0d want 0", hold_viol - hb); else passed++;
    total++; if (ready_viol != rb) $display("FAIL mix_ready_low got %0d want 0", ready_viol - rb); else passed++;
    total++; if (obs_q.size() != exp_q.size()) $display("FAIL mix_rsp_count got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
    for (int i = ob; i < exp_q.size() && i < obs_q.size(); i++) begin
      if (exp_q[i].rd) model_last = exp_q[i].data;
      total++;
      if (obs_q[i] !== {exp_q[i].err, model_last}) $display("FAIL mix_rsp[%0d] got err=%0b data=%0h want err=%0b data=%0h", i, obs_q[i].err, obs_q[i].data, exp_q[i].err, model_last);
      else passed++;
    end
  endtask

  task automatic test_reset_during_wait();
    int ab, ob;
    stall_fixed = 5;
    send_cmd(1'b0, 10'h050, '0);
    send_cmd(1'b0, 10'h054, '0);
    cmd_valid = 1'b0;
    @(posedge HCLK); #1;
    total++; if (HREADY !== 1'b0) $display("FAIL rstw_in_wait got HREADY=%0b want 0", HREADY); else passed++;
    HRESETn = 1'b0;
    @(posedge HCLK); #1;
    total++; if (HTRANS !== 2'b00) $display("FAIL rstw_htrans got %0h want 0", HTRANS); else passed++;
    total++; if (rsp_valid !== 1'b0) $display("FAIL rstw_rsp_valid got %0b want 0", rsp_valid); else passed++;
    HRESETn = 1'b1;
    stall_fixed = 0;
    while (exp_q.size() > obs_q.size()) exp_q.pop_back();
    model_last = '0;
    ab = aph_q.size();
    ob = obs_q.size();
    repeat (10) @(posedge HCLK);
    #1;
    total++; if (aph_q.size() != ab) $display("FAIL rstw_no_replay got %0d aphases want 0", aph_q.size() - ab); else passed++;
    total++; if (obs_q.size() != ob) $display("FAIL rstw_no_rsp got %0d rsp want 0", obs_q.size() - ob); else passed++;
  endtask

  task automatic test_timeout();
    logic exp_flag;
`ifdef WAIT_TIMEOUT_EN
    exp_flag = 1'b1;
`else
    exp_flag = 1'b0;
`endif
    stall_fixed = 63;
    send_cmd(1'b0, 10'h060, '0);
    drain();
    total++; if (timeout_flag !== 1'b0) $display("FAIL tmo_63 got %0b want 0", timeout_flag); else passed++;
    stall_fixed = 64;
    send_cmd(1'b0, 10'h064, '0);
    drain();
    stall_fixed = 0;
    total++; if (timeout_flag !== exp_flag) $display("FAIL tmo_64 got %0b want %0b", timeout_flag, exp_flag); else passed++;
    send_cmd(1'b1, 10'h068, $urandom);
    drain();
    total++; if (timeout_flag !== exp_flag) $display("FAIL tmo_sticky got %0b want %0b", timeout_flag, exp_flag); else passed++;
    total++; if (obs_q.size() != exp_q.size()) $display("FAIL tmo_rsp_count got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      refmem[i] = $urandom;
      smem[i]   = refmem[i];
    end
    test_reset();
    test_write_read();
    test_wait_states();
    test_error_replay();
    test_back_to_back();
    test_random_mix();
    test_reset_during_wait();
    test_timeout();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
